// File: rtl/pulse_meter.sv
// rtl/pulse_meter.sv - pulse width and rising-to-rising period meter
// Publishes one width/period pair per completed high+low cycle of the synchronized input.
module pulse_meter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             signal,
  input  logic             enable,
  output logic [CNT_W-1:0] width,
  output logic [CNT_W-1:0] period,
  output logic             valid,
  output logic             overflow,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    HIGH  = 2'd2,
    LOW   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s_prev_q, s_prev_d;
  logic [CNT_W-1:0]       width_cnt_q, width_cnt_d;
  logic [CNT_W-1:0]       period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0]       width_q, width_d;
  logic [CNT_W-1:0]       period_q, period_d;
  logic                   valid_q, valid_d;
  logic                   overflow_q, overflow_d;
  logic                   busy_q, busy_d;

  logic s;
  logic rise;
  logic fall;

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~s_prev_q;
  assign fall = ~s & s_prev_q;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_ONE;
  endfunction

  always_comb begin
    sync_d       = {sync_q[SYNC_STAGES-2:0], signal};
    s_prev_d     = s;
    state_d      = state_q;
    width_cnt_d  = width_cnt_q;
    period_cnt_d = period_cnt_q;
    width_d      = width_q;
    period_d     = period_q;
    valid_d      = 1'b0;
    overflow_d   = overflow_q;

    // Disable overrides everything, including a rise seen in the same cycle.
    if (!enable) begin
      state_d      = IDLE;
      width_cnt_d  = '0;
      period_cnt_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = ARMED;
        end
        ARMED: begin
          if (rise) begin
            state_d      = HIGH;
            width_cnt_d  = CNT_ONE;
            period_cnt_d = CNT_ONE;
          end
        end
        HIGH: begin
          if (fall) begin
            state_d      = LOW;
            period_cnt_d = sat_inc(period_cnt_q);
          end else begin
            width_cnt_d  = sat_inc(width_cnt_q);
            period_cnt_d = sat_inc(period_cnt_q);
          end
        end
        LOW: begin
          if (rise) begin
            state_d      = HIGH;
            width_d      = width_cnt_q;
            period_d     = period_cnt_q;
            valid_d      = 1'b1;
            overflow_d   = overflow_q | (width_cnt_q == CNT_MAX) | (period_cnt_q == CNT_MAX);
            width_cnt_d  = CNT_ONE;
            period_cnt_d = CNT_ONE;
          end else begin
            period_cnt_d = sat_inc(period_cnt_q);
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      sync_q       <= '0;
      s_prev_q     <= 1'b0;
      width_cnt_q  <= '0;
      period_cnt_q <= '0;
      width_q      <= '0;
      period_q     <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_d;
      s_prev_q     <= s_prev_d;
      width_cnt_q  <= width_cnt_d;
      period_cnt_q <= period_cnt_d;
      width_q      <= width_d;
      period_q     <= period_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      busy_q       <= busy_d;
    end
  end

  assign width    = width_q;
  assign period   = period_q;
  assign valid    = valid_q;
  assign overflow = overflow_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_pulse_meter.sv
// tb/tb_pulse_meter.sv - directed bench for pulse_meter (8-bit and 4-bit counter instances)
module tb_pulse_meter;

  localparam int S = 2;

  logic       clock;
  logic       reset;
  logic       signal;
  logic       enable;
  logic [7:0] width8, period8;
  logic       valid8, overflow8, busy8;
  logic [3:0] width4, period4;
  logic       valid4, overflow4, busy4;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  int vq[$];
  int wq[$];
  int pq[$];
  int w4q[$];
  int p4q[$];

  pulse_meter #(.CNT_W(8), .SYNC_STAGES(S)) u_dut8 (
    .clock   (clock),
    .reset   (reset),
    .signal  (signal),
    .enable  (enable),
    .width   (width8),
    .period  (period8),
    .valid   (valid8),
    .overflow(overflow8),
    .busy    (busy8)
  );

  pulse_meter #(.CNT_W(4), .SYNC_STAGES(S)) u_dut4 (
    .clock   (clock),
    .reset   (reset),
    .signal  (signal),
    .enable  (enable),
    .width   (width4),
    .period  (period4),
    .valid   (valid4),
    .overflow(overflow4),
    .busy    (busy4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (valid8 === 1'b1) begin
      vq.push_back(cyc);
      wq.push_back(int'(width8));
      pq.push_back(int'(period8));
    end
    if (valid4 === 1'b1) begin
      w4q.push_back(int'(width4));
      p4q.push_back(int'(period4));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    signal = 1'b1;
    step(hi);
    signal = 1'b0;
    step(lo);
  endtask

  task automatic restart();
    enable = 1'b0;
    signal = 1'b0;
    reset  = 1'b1;
    step(1);
    reset  = 1'b0;
    enable = 1'b1;
    step(4);
  endtask

  initial begin
    int base;
    int base4;
    int r2;

    // 1: reset held with enable high and signal toggling
    reset  = 1'b1;
    enable = 1'b1;
    signal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      signal = ~signal;
      check($sformatf("rst8_c%0d", i), {width8, period8, valid8, overflow8, busy8}, 32'd0);
      check($sformatf("rst4_c%0d", i), {width4, period4, valid4, overflow4, busy4}, 32'd0);
    end

    // 2: steady train, high 4 / low 6, four pulses
    restart();
    base = vq.size();
    pulse(4, 6);
    r2 = cyc;
    pulse(4, 6);
    pulse(4, 6);
    pulse(4, 6);
    step(2);
    check("train_count", vq.size() - base, 3);
    for (int i = 0; i < vq.size() - base; i++) begin
      check($sformatf("train_cyc%0d", i), vq[base+i], r2 + S + 1 + 10 * i);
      check($sformatf("train_w%0d", i), wq[base+i], 4);
      check($sformatf("train_p%0d", i), pq[base+i], 10);
    end
    check("train_ovf", overflow8, 0);

    // 3: minimum pulse, one high / one low
    restart();
    base = vq.size();
    for (int i = 0; i < 6; i++) pulse(1, 1);
    step(6);
    check("min_count", vq.size() - base, 5);
    for (int i = 0; i < vq.size() - base; i++) begin
      check($sformatf("min_w%0d", i), wq[base+i], 1);
      check($sformatf("min_p%0d", i), pq[base+i], 2);
      if (i > 0) check($sformatf("min_gap%0d", i), vq[base+i] - vq[base+i-1], 2);
    end

    // 4: saturation on the 4-bit instance, then an in-range pulse
    restart();
    base  = vq.size();
    base4 = w4q.size();
    pulse(20, 5);
    pulse(3, 3);
    pulse(1, 1);
    step(6);
    check("sat4_count", w4q.size() - base4, 2);
    check("sat8_count", vq.size() - base, 2);
    if (w4q.size() - base4 >= 2) begin
      check("sat4_w", w4q[base4], 15);
      check("sat4_p", p4q[base4], 15);
      check("sat4_w_next", w4q[base4+1], 3);
      check("sat4_p_next", p4q[base4+1], 6);
    end
    if (vq.size() - base >= 1) begin
      check("sat8_w", wq[base], 20);
      check("sat8_p", pq[base], 25);
    end
    check("sat4_ovf_sticky", overflow4, 1);
    check("sat4_width_end", width4, 3);
    check("sat8_ovf", overflow8, 0);

    // 5: enable dropped in the cycle the rise is detected
    restart();
    pulse(4, 6);
    pulse(4, 6);
    step(2);
    base = vq.size();
    signal = 1'b1;
    step(S);
    enable = 1'b0;
    step(1);
    check("drop_valid", valid8, 0);
    check("drop_busy", busy8, 0);
    check("drop_w_kept", width8, 4);
    check("drop_p_kept", period8, 10);
    step(3);
    check("drop_no_pub", vq.size() - base, 0);
    enable = 1'b1;
    step(3);
    check("rearm_busy", busy8, 1);
    signal = 1'b0;
    step(3);
    pulse(2, 3);
    check("rearm_one_rise", vq.size() - base, 0);
    pulse(5, 3);
    check("rearm_count", vq.size() - base, 1);
    if (vq.size() - base >= 1) begin
      check("rearm_w", wq[base], 2);
      check("rearm_p", pq[base], 5);
    end

    // 6: reset during LOW after one publish
    restart();
    pulse(3, 4);
    pulse(3, 4);
    check("mid_pre_w", width8, 3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("mid_w", width8, 0);
    check("mid_p", period8, 0);
    check("mid_valid", valid8, 0);
    check("mid_ovf", overflow8, 0);
    check("mid_busy", busy8, 0);
    step(1);
    check("mid_rearm_busy", busy8, 1);
    base = vq.size();
    step(2);
    pulse(2, 2);
    pulse(2, 2);
    pulse(2, 2);
    step(4);
    check("mid_count", vq.size() - base, 2);
    if (vq.size() - base >= 1) begin
      check("mid_after_w", wq[base], 2);
      check("mid_after_p", pq[base], 4);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/pulse_meter.md
# pulse_meter

Measures an incoming pulse train: counts high-time (width) and rising-to-rising interval (period) in clock cycles. Publishes each completed measurement with a one-cycle valid strobe. Sits on the receiving end of the pulse generators and supplies cycle-accurate pulse timing to checkers and control logic.

## Interface

**Parameters**
- `CNT_W`, default 8: width of the width and period counters and outputs.
- `SYNC_STAGES`, default 2 (minimum 2): synchronizer depth for `signal`.

**Ports**
- `clock`, input, 1: single clock, rising-edge active.
- `reset`, input, 1: synchronous, active-high; clears all state.
- `signal`, input, 1: asynchronous pulse input to be measured.
- `enable`, input, 1: measurement enable, level-sensitive.
- `width`, output, CNT_W: high-time of the last completed pulse, in cycles.
- `period`, output, CNT_W: last rising-to-rising interval, in cycles.
- `valid`, output, 1: one-cycle strobe when `width` and `period` update.
- `overflow`, output, 1: sticky; set when any published value saturated.
- `busy`, output, 1: high whenever state is not IDLE.

## Operation

**Input conditioning**
- `signal` passes through SYNC_STAGES flops to produce `s`.
- One further flop holds `s_prev`. These flops run regardless of state and `enable`.
- `rise = s & ~s_prev`; `fall = ~s & s_prev`.

**States**
- IDLE → ARMED when `enable` = 1.
- ARMED, on `rise` → HIGH. Sets `width_cnt` = 1 and `period_cnt` = 1. A `signal` that is already high when armed does not count as a rise.
- HIGH, each cycle with `s` = 1 → `width_cnt`++ and `period_cnt`++. On `fall` → LOW, with `period_cnt`++ and `width_cnt` held.
- LOW, each cycle → `period_cnt`++. On `rise`:
  - publish `width` ← `width_cnt` and `period` ← `period_cnt`;
  - assert `valid`;
  - set both counters to 1;
  - go to HIGH.
- Any state with `enable` = 0 → IDLE. Counters clear to 0; `width` and `period` are retained; no `valid` is produced.

**Arithmetic**
- Counters saturate at 2^CNT_W−1 and never wrap.
- If either published value equals the saturated maximum, `overflow` is set. It stays set until `reset`.

**Boundary conditions**
- Only a completed high+low cycle publishes. The first pulse after arming publishes nothing.
- A single-cycle high on `s` gives width = 1. High or low phases shorter than one clock period may be missed; this is accepted behaviour.
- If `rise` and `enable` = 0 occur in the same cycle, disable wins: go to IDLE, no `valid`.
- `reset` mid-measurement: state IDLE, counters 0, `width` = 0, `period` = 0, `valid` = 0, `overflow` = 0, `busy` = 0 on the next edge.

## Timing

- All outputs are registered. Reset value of every output is 0.
- `s` follows `signal` SYNC_STAGES edges after the first edge that samples a change.
- `rise` is combinational on `s`/`s_prev`. Publish happens on the edge after `rise` is seen.
- Latency is SYNC_STAGES+1 rising edges, from the first edge sampling `signal` high to `valid` = 1.
- `valid` is high for exactly one cycle per measurement. `width` and `period` change only in that cycle, and hold until the next publish or `reset`.
- `busy` rises one edge after `enable` is sampled high in IDLE. It falls one edge after `enable` is sampled low.
- Back-to-back publishes are possible with a minimum period of 2: one cycle high, one cycle low.

## Test plan

1. **Reset values.** Hold `reset` for 3 cycles, with `enable` = 1 and `signal` toggling. → All outputs 0, `busy` = 0 throughout.
2. **Steady train.** `enable` = 1; `signal` high 4 cycles, low 6 cycles, repeated 4 times. → First `valid` appears at the second rise + SYNC_STAGES+1 edges, with `width` = 4 and `period` = 10. Exactly 3 `valid` strobes; `overflow` = 0.
3. **Minimum pulse.** `signal` alternates 1 cycle high, 1 cycle low. → `valid` every 2 cycles after the first publish, with `width` = 1 and `period` = 2.
4. **Saturation** (CNT_W = 4). Pulses of high 20, low 5. → `width` = 15, `period` = 15, `overflow` = 1 and stays 1 after a later in-range pulse (high 3, low 3) publishes `width` = 3, `period` = 6.
5. **Enable drop.** Drop `enable` in the cycle `rise` is detected. → No `valid`; `busy` = 0 next edge; previous `width`/`period` retained. After re-enabling with `signal` already high, nothing publishes until two genuine rises have occurred.
6. **Mid-operation reset.** Assert `reset` for 1 cycle during LOW, after one publish. → Outputs 0 next edge; the subsequent measurement restarts from ARMED.
